// File: rtl/asi_core_p.sv
// asi_core_p: parametrised ASI execution core with a valid/ready instruction port and a debug port.
// Define ASI_FAST_MUL_EN for a single-cycle multiplier; otherwise MUL/MULI use an XLEN-cycle shift-add loop.
module asi_core_p #(
    parameter int XLEN  = 32,
    parameter int NREGS = 64,
    parameter int PC_W  = 24
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [31:0]     instruction,
    output logic [XLEN-1:0] data1,
    output logic [XLEN-1:0] data2,
    output logic [XLEN-1:0] data_rd,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] ra,
    output logic            retire,
    output logic            illegal,
    input  logic            dbg_we,
    input  logic [7:0]      dbg_addr,
    input  logic [XLEN-1:0] dbg_wdata,
    output logic [XLEN-1:0] dbg_rdata
);

    localparam int IW = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam int CW = $clog2(XLEN + 1);
`ifdef ASI_FAST_MUL_EN
    localparam bit ITER_MUL = 1'b0;
`else
    localparam bit ITER_MUL = 1'b1;
`endif

    typedef enum logic {IDLE, MUL} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];
    logic [PC_W-1:0] pc_q, pc_d, ra_q, ra_d;
    logic [XLEN-1:0] data1_q, data1_d, data2_q, data2_d, data_rd_q, data_rd_d;
    logic            retire_q, retire_d, illegal_q, illegal_d;
    logic [XLEN-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
    logic [XLEN-1:0] mop1_q, mop1_d, mop2_q, mop2_d;
    logic [7:0]      mdst_q, mdst_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [7:0]      opcode, f_a, f_b, f_c;
    logic [XLEN-1:0] a_val, b_val, c_val, op1, op2, alu_res, acc_sum;
    logic            is_imm, is_shift, is_mul, is_alu, wr_en;
    logic [7:0]      wr_idx;
    logic [XLEN-1:0] wr_val;

    function automatic logic in_range(input logic [7:0] idx);
        return int'(idx) < NREGS;
    endfunction

    assign opcode = instruction[31:24];
    assign f_a    = instruction[23:16];
    assign f_b    = instruction[15:8];
    assign f_c    = instruction[7:0];

    assign a_val     = in_range(f_a) ? regs_q[f_a[IW-1:0]] : '0;
    assign b_val     = in_range(f_b) ? regs_q[f_b[IW-1:0]] : '0;
    assign c_val     = in_range(f_c) ? regs_q[f_c[IW-1:0]] : '0;
    assign dbg_rdata = in_range(dbg_addr) ? regs_q[dbg_addr[IW-1:0]] : '0;

    assign is_imm   = opcode inside {8'h45, 8'h46, 8'h47, 8'h4A, 8'h4B, 8'h4C};
    assign is_shift = opcode inside {8'h48, 8'h49};
    assign is_mul   = opcode inside {8'h0A, 8'h4C};
    assign is_alu   = is_imm || is_shift || (opcode inside {8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A});

    assign op1 = is_imm ? a_val : b_val;
    assign op2 = is_imm ? XLEN'(instruction[15:0]) : (is_shift ? XLEN'(f_c) : c_val);

    always_comb begin
        alu_res = '0;
        case (opcode)
            8'h05, 8'h45: alu_res = op1 & op2;
            8'h06, 8'h46: alu_res = op1 | op2;
            8'h07, 8'h47: alu_res = op1 ^ op2;
            8'h08, 8'h4A: alu_res = op1 + op2;
            8'h09, 8'h4B: alu_res = op1 - op2;
            8'h0A, 8'h4C: alu_res = ITER_MUL ? '0 : op1 * op2;
            8'h48:        alu_res = (int'(f_c) >= XLEN) ? '0 : op1 << f_c;
            8'h49:        alu_res = (int'(f_c) >= XLEN) ? '0 : op1 >> f_c;
            default:      alu_res = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        regs_d    = regs_q;
        pc_d      = pc_q;
        ra_d      = ra_q;
        data1_d   = data1_q;
        data2_d   = data2_q;
        data_rd_d = data_rd_q;
        retire_d  = 1'b0;
        illegal_d = 1'b0;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        mop1_d    = mop1_q;
        mop2_d    = mop2_q;
        mdst_d    = mdst_q;
        cnt_d     = cnt_q;
        wr_en     = 1'b0;
        wr_idx    = f_a;
        wr_val    = alu_res;
        acc_sum   = acc_q + (mplier_q[0] ? mcand_q : '0);

        case (state_q)
            IDLE: begin
                if (instr_valid) begin
                    if (is_mul && ITER_MUL) begin
                        state_d  = MUL;
                        mcand_d  = op1;
                        mplier_d = op2;
                        mop1_d   = op1;
                        mop2_d   = op2;
                        mdst_d   = f_a;
                        acc_d    = '0;
                        cnt_d    = '0;
                    end else begin
                        pc_d      = pc_q + PC_W'(1);
                        retire_d  = 1'b1;
                        data1_d   = '0;
                        data2_d   = '0;
                        data_rd_d = '0;
                        if (is_alu) begin
                            data1_d   = op1;
                            data2_d   = op2;
                            data_rd_d = alu_res;
                            wr_en     = 1'b1;
                        end else begin
                            case (opcode)
                                8'h41, 8'h42: begin
                                    data1_d = a_val;
                                    data2_d = b_val;
                                    if ((a_val == b_val) == (opcode == 8'h41))
                                        pc_d = pc_q + {{(PC_W-8){f_c[7]}}, f_c};
                                end
                                8'h01: pc_d = PC_W'(instruction[23:0]);
                                8'h02: begin
                                    ra_d = pc_q + PC_W'(1);
                                    pc_d = PC_W'(instruction[23:0]);
                                end
                                default: illegal_d = 1'b1;
                            endcase
                        end
                    end
                end
            end
            MUL: begin
                // One multiplier bit per cycle; the final step writes back the last partial sum.
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(XLEN - 1)) begin
                    state_d   = IDLE;
                    wr_en     = 1'b1;
                    wr_idx    = mdst_q;
                    wr_val    = acc_sum;
                    data1_d   = mop1_q;
                    data2_d   = mop2_q;
                    data_rd_d = acc_sum;
                    pc_d      = pc_q + PC_W'(1);
                    retire_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Debug write is applied first so an instruction writeback to the same index overrides it.
        if (dbg_we && in_range(dbg_addr))
            regs_d[dbg_addr[IW-1:0]] = dbg_wdata;
        if (wr_en && in_range(wr_idx))
            regs_d[wr_idx[IW-1:0]] = wr_val;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
            pc_q      <= '0;
            ra_q      <= '0;
            data1_q   <= '0;
            data2_q   <= '0;
            data_rd_q <= '0;
            retire_q  <= 1'b0;
            illegal_q <= 1'b0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            mop1_q    <= '0;
            mop2_q    <= '0;
            mdst_q    <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            regs_q    <= regs_d;
            pc_q      <= pc_d;
            ra_q      <= ra_d;
            data1_q   <= data1_d;
            data2_q   <= data2_d;
            data_rd_q <= data_rd_d;
            retire_q  <= retire_d;
            illegal_q <= illegal_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            mop1_q    <= mop1_d;
            mop2_q    <= mop2_d;
            mdst_q    <= mdst_d;
            cnt_q     <= cnt_d;
        end
    end

    assign instr_ready = (state_q == IDLE);
    assign pc          = pc_q;
    assign ra          = ra_q;
    assign data1       = data1_q;
    assign data2       = data2_q;
    assign data_rd     = data_rd_q;
    assign retire      = retire_q;
    assign illegal     = illegal_q;

endmodule

// File: tb/tb_asi_core_p.sv
// Self-checking bench for asi_core_p: a table of single-cycle instructions plus
// hand-written sequences for the iterative multiply, debug collision and reset abort.
module tb_asi_core_p;

   localparam int XLEN = 32;
   localparam int PC_W = 24;

   logic            clock = 1'b0;
   logic            reset;
   logic            instr_valid;
   logic            instr_ready;
   logic [31:0]     instruction;
   logic [XLEN-1:0] data1, data2, data_rd;
   logic [PC_W-1:0] pc, ra;
   logic            retire, illegal;
   logic            dbg_we;
   logic [7:0]      dbg_addr;
   logic [XLEN-1:0] dbg_wdata, dbg_rdata;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] instr;
      logic [7:0]  chkIdx;
      logic [31:0] expReg;
      logic [23:0] expPc;
      logic [23:0] expRa;
      logic [31:0] expRd;
      logic        expIll;
   } vec_t;

   vec_t vecs[18];

   asi_core_p #(.XLEN(XLEN), .NREGS(64), .PC_W(PC_W)) dut (
      .clock(clock), .reset(reset),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instruction(instruction),
      .data1(data1), .data2(data2), .data_rd(data_rd),
      .pc(pc), .ra(ra), .retire(retire), .illegal(illegal),
      .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata)
   );

   // Free-running 10-unit clock
   always #5 clock = ~clock;

   // Safety net so the run can never hang
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, want finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // One comparison: counts it and reports a mismatch with both values
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
      end
   endtask

   // Presents one instruction for a single edge, then samples just after it
   task automatic applyStimulus(input logic [31:0] instr);
      instr_valid = 1'b1;
      instruction = instr;
      @(posedge clock);
      #1;
      instr_valid = 1'b0;
   endtask

   // Loads a register through the debug port
   task automatic dbgWrite(input logic [7:0] idx, input logic [31:0] val);
      dbg_we    = 1'b1;
      dbg_addr  = idx;
      dbg_wdata = val;
      @(posedge clock);
      #1;
      dbg_we = 1'b0;
   endtask

   // Combinational register peek through the debug port
   task automatic readReg(input logic [7:0] idx, output logic [31:0] val);
      dbg_addr = idx;
      #1;
      val = dbg_rdata;
   endtask

   initial begin
      logic [31:0] rv;
      int lowCount;
      int stallRetires;
      int lateRetires;

      // Expected results worked out by hand, starting from pc=0 after the preloads below
      vecs[0]  = '{32'h08030102, 8'd3,   32'd0,        24'd1,       24'd0, 32'd0,        1'b0};
      vecs[1]  = '{32'h09040201, 8'd4,   32'd2,        24'd2,       24'd0, 32'd2,        1'b0};
      vecs[2]  = '{32'h4A160064, 8'd22,  32'd400,      24'd3,       24'd0, 32'd400,      1'b0};
      vecs[3]  = '{32'h481A1602, 8'd26,  32'd1600,     24'd4,       24'd0, 32'd1600,     1'b0};
      vecs[4]  = '{32'h0506011E, 8'd6,   32'd7,        24'd5,       24'd0, 32'd7,        1'b0};
      vecs[5]  = '{32'h49071620, 8'd7,   32'd0,        24'd6,       24'd0, 32'd0,        1'b0};
      vecs[6]  = '{32'h49081602, 8'd8,   32'd100,      24'd7,       24'd0, 32'd100,      1'b0};
      vecs[7]  = '{32'h4B1600C8, 8'd22,  32'd200,      24'd8,       24'd0, 32'd200,      1'b0};
      vecs[8]  = '{32'h46500001, 8'h50,  32'd0,        24'd9,       24'd0, 32'd1,        1'b0};
      vecs[9]  = '{32'h07090102, 8'd9,   32'hFFFFFFFE, 24'd10,      24'd0, 32'hFFFFFFFE, 1'b0};
      vecs[10] = '{32'h411D1EFC, 8'd29,  32'd7,        24'd6,       24'd0, 32'd0,        1'b0};
      vecs[11] = '{32'h421D1E08, 8'd30,  32'd7,        24'd7,       24'd0, 32'd0,        1'b0};
      vecs[12] = '{32'h42010203, 8'd1,   32'hFFFFFFFF, 24'd10,      24'd0, 32'd0,        1'b0};
      vecs[13] = '{32'h01000005, 8'd1,   32'hFFFFFFFF, 24'd5,       24'd0, 32'd0,        1'b0};
      vecs[14] = '{32'h02000100, 8'd9,   32'hFFFFFFFE, 24'h100,     24'd6, 32'd0,        1'b0};
      vecs[15] = '{32'hFF000000, 8'd9,   32'hFFFFFFFE, 24'h101,     24'd6, 32'd0,        1'b1};
      vecs[16] = '{32'h01FFFFFF, 8'd9,   32'hFFFFFFFE, 24'hFFFFFF,  24'd6, 32'd0,        1'b0};
      vecs[17] = '{32'h00000000, 8'd9,   32'hFFFFFFFE, 24'd0,       24'd6, 32'd0,        1'b1};

      reset       = 1'b0;
      instr_valid = 1'b0;
      instruction = '0;
      dbg_we      = 1'b0;
      dbg_addr    = '0;
      dbg_wdata   = '0;

      // Reset state
      repeat (2) @(posedge clock);
      #1;
      checkOutput("reset_pc", 32'(pc), 32'd0);
      checkOutput("reset_ready", 32'(instr_ready), 32'd1);
      checkOutput("reset_retire", 32'(retire), 32'd0);
      checkOutput("reset_data_rd", data_rd, 32'd0);
      reset = 1'b1;
      @(posedge clock);
      #1;

      // Preload operands used by the vector table and the multiply sequence
      dbgWrite(8'd1, 32'hFFFFFFFF);
      dbgWrite(8'd2, 32'd1);
      dbgWrite(8'd22, 32'd300);
      dbgWrite(8'd24, 32'd300);
      dbgWrite(8'd29, 32'd7);
      dbgWrite(8'd30, 32'd7);
      readReg(8'd1, rv);
      checkOutput("preload_r1", rv, 32'hFFFFFFFF);

      // Table-driven single-cycle instructions, issued back to back
      for (int i = 0; i < 18; i++) begin
         applyStimulus(vecs[i].instr);
         checkOutput($sformatf("v%0d_retire", i), 32'(retire), 32'd1);
         checkOutput($sformatf("v%0d_illegal", i), 32'(illegal), 32'(vecs[i].expIll));
         checkOutput($sformatf("v%0d_pc", i), 32'(pc), 32'(vecs[i].expPc));
         checkOutput($sformatf("v%0d_ra", i), 32'(ra), 32'(vecs[i].expRa));
         checkOutput($sformatf("v%0d_data_rd", i), data_rd, vecs[i].expRd);
         readReg(vecs[i].chkIdx, rv);
         checkOutput($sformatf("v%0d_reg", i), rv, vecs[i].expReg);
      end

      // Iterative MULI with a following ADDI held valid through the stall
      instr_valid = 1'b1;
      instruction = 32'h4C180064;
      @(posedge clock);
      #1;
      instruction = 32'h4A180001;
      lowCount = 0;
      stallRetires = 0;
      while (!instr_ready && lowCount < 100) begin
         lowCount++;
         if (retire) stallRetires++;
         @(posedge clock);
         #1;
      end
      checkOutput("mul_stall_cycles", 32'(lowCount), 32'd32);
      checkOutput("mul_stall_retires", 32'(stallRetires), 32'd0);
      checkOutput("mul_retire", 32'(retire), 32'd1);
      checkOutput("mul_data_rd", data_rd, 32'd30000);
      checkOutput("mul_data1", data1, 32'd300);
      checkOutput("mul_data2", data2, 32'd100);
      checkOutput("mul_pc", 32'(pc), 32'd1);
      readReg(8'd24, rv);
      checkOutput("mul_reg24", rv, 32'd30000);
      @(posedge clock);
      #1;
      instr_valid = 1'b0;
      checkOutput("held_retire", 32'(retire), 32'd1);
      checkOutput("held_data_rd", data_rd, 32'd30001);
      checkOutput("held_pc", 32'(pc), 32'd2);
      @(posedge clock);
      #1;
      checkOutput("held_once_retire", 32'(retire), 32'd0);
      checkOutput("held_once_pc", 32'(pc), 32'd2);
      readReg(8'd24, rv);
      checkOutput("held_once_reg24", rv, 32'd30001);

      // Debug write and instruction writeback to the same register on the same edge
      dbg_we      = 1'b1;
      dbg_addr    = 8'd9;
      dbg_wdata   = 32'h1234;
      instr_valid = 1'b1;
      instruction = 32'h4A090001;
      @(posedge clock);
      #1;
      dbg_we      = 1'b0;
      instr_valid = 1'b0;
      readReg(8'd9, rv);
      checkOutput("collide_reg9", rv, 32'hFFFFFFFF);

      // Reset in the middle of a multiply aborts it; debug writes still land while stalled
      dbgWrite(8'd1, 32'd5);
      dbgWrite(8'd2, 32'd3);
      applyStimulus(32'h0A030102);
      dbgWrite(8'd10, 32'h55);
      readReg(8'd10, rv);
      checkOutput("mulstate_dbg_write", rv, 32'h55);
      repeat (3) @(posedge clock);
      #1;
      checkOutput("mulstate_ready", 32'(instr_ready), 32'd0);
      reset = 1'b0;
      #1;
      readReg(8'd1, rv);
      checkOutput("abort_reg1", rv, 32'd0);
      checkOutput("abort_pc", 32'(pc), 32'd0);
      checkOutput("abort_ready", 32'(instr_ready), 32'd1);
      checkOutput("abort_retire", 32'(retire), 32'd0);
      @(posedge clock);
      #1;
      reset = 1'b1;
      lateRetires = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clock);
         #1;
         if (retire) lateRetires++;
      end
      checkOutput("abort_no_retire", 32'(lateRetires), 32'd0);
      readReg(8'd3, rv);
      checkOutput("abort_reg3", rv, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
